// File: rtl/rv32i_types.sv
// Shared rename-stage types: default machine sizes and the physical register index.
package rv32i_types;

    localparam int PREG_WIDTH_DEF = 6;
    localparam int NUM_PREGS_DEF  = 64;
    localparam int NUM_AREGS_DEF  = 32;
    localparam int WAYS_DEF       = 2;

    typedef logic [PREG_WIDTH_DEF-1:0] preg_t;

endpackage

// File: rtl/popcount_prefix.sv
// Per-way exclusive prefix count and total popcount of a WAYS-wide request vector.
module popcount_prefix #(
    parameter int WAYS = 2,
    parameter int CW   = $clog2(WAYS) + 1
) (
    input  logic [WAYS-1:0]         vec_i,
    output logic [WAYS-1:0][CW-1:0] prefix_o,
    output logic [CW-1:0]           total_o
);

    // Running sum: way i sees the number of set bits strictly below it.
    always_comb begin
        logic [CW-1:0] acc;
        acc      = '0;
        prefix_o = '0;
        for (int i = 0; i < WAYS; i++) begin
            prefix_o[i] = acc;
            acc         = acc + CW'(vec_i[i]);
        end
        total_o = acc;
    end

endmodule

// File: rtl/free_list_mw.sv
// Multi-way physical register free list: circular buffer of free indices with a
// speculative head (alloc), a tail (frees) and a retire head (committed allocs)
// that the speculative head snaps back to on flush.
module free_list_mw
    import rv32i_types::*;
#(
    parameter  int PREG_WIDTH = PREG_WIDTH_DEF,
    parameter  int NUM_PREGS  = NUM_PREGS_DEF,
    parameter  int NUM_AREGS  = NUM_AREGS_DEF,
    parameter  int WAYS       = WAYS_DEF,
    localparam int DEPTH      = NUM_PREGS - NUM_AREGS,
    localparam int PW         = $clog2(DEPTH) + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [WAYS-1:0]                  alloc_req,
    output logic [WAYS-1:0][PREG_WIDTH-1:0]  alloc_preg,
    output logic                             alloc_ok,
    input  logic [WAYS-1:0]                  free_valid,
    input  logic [WAYS-1:0][PREG_WIDTH-1:0]  free_preg,
    input  logic [WAYS-1:0]                  commit_alloc,
    input  logic                             flush,
    output logic [PW-1:0]                    free_count
);

    localparam int IW = PW - 1;
    localparam int CW = $clog2(WAYS) + 1;

    logic [PREG_WIDTH-1:0] mem_q [DEPTH];
    logic [PREG_WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d, retire_q, retire_d;

    logic [WAYS-1:0][CW-1:0] a_pre, f_pre, c_pre;
    logic [CW-1:0]           a_tot, f_tot, c_tot;

    popcount_prefix #(.WAYS(WAYS), .CW(CW)) u_pc_alloc (
        .vec_i(alloc_req), .prefix_o(a_pre), .total_o(a_tot)
    );
    popcount_prefix #(.WAYS(WAYS), .CW(CW)) u_pc_free (
        .vec_i(free_valid), .prefix_o(f_pre), .total_o(f_tot)
    );
    popcount_prefix #(.WAYS(WAYS), .CW(CW)) u_pc_commit (
        .vec_i(commit_alloc), .prefix_o(c_pre), .total_o(c_tot)
    );

    // Commit prefixes are not needed: commits only move retire_head by a total.
    logic unused_c_pre;
    assign unused_c_pre = ^c_pre;

    // Wrap-bit pointers make the modular difference the true occupancy.
    assign free_count = tail_q - head_q;

    // All-or-nothing grant, judged against the pre-update count (no free bypass).
    assign alloc_ok = !rst && !flush && (int'(a_tot) <= int'(free_count));

    // Compacted read: the k-th requesting way takes the entry k past head.
    always_comb begin
        alloc_preg = '0;
        for (int i = 0; i < WAYS; i++) begin
            alloc_preg[i] = mem_q[IW'(head_q + PW'(a_pre[i]))];
        end
    end

    // Next-state: frees land compacted at tail; flush rewinds head past this cycle's commits.
    always_comb begin
        mem_d = mem_q;
        for (int j = 0; j < WAYS; j++) begin
            if (free_valid[j]) begin
                mem_d[IW'(tail_q + PW'(f_pre[j]))] = free_preg[j];
            end
        end
        tail_d   = tail_q + PW'(f_tot);
        retire_d = retire_q + PW'(c_tot);
        if (flush) begin
            head_d = retire_d;
        end else if (alloc_ok) begin
            head_d = head_q + PW'(a_tot);
        end else begin
            head_d = head_q;
        end
    end

    // State registers; reset refills the list with every non-architectural index.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= PREG_WIDTH'(NUM_AREGS + i);
            end
            head_q   <= '0;
            retire_q <= '0;
            tail_q   <= PW'(DEPTH);
        end else begin
            mem_q    <= mem_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            retire_q <= retire_d;
        end
    end

    // Entries still held between retire_head and tail (slots committed this
    // cycle are released); a free must not overwrite one of them.
    logic [PW-1:0] held_after_commit;
    assign held_after_commit = tail_q - retire_d;

    // Protocol check: returning more registers than the buffer can hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (int'(held_after_commit) + int'(f_tot) <= DEPTH)
            else $error("free_list_mw: free overflow");
        end
    end

endmodule

// File: tb/tb_free_list_mw.sv
// Bench for free_list_mw: directed table, hand sequences and random traffic vs a queue model.
module tb_free_list_mw;
    import rv32i_types::*;

    localparam int DEPTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       alloc_req, free_valid, commit_alloc;
    logic [1:0][5:0]  alloc_preg, free_preg;
    logic             alloc_ok, flush;
    logic [5:0]       free_count;

    always #5 clk = ~clk;

    free_list_mw dut (
        .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_preg(alloc_preg),
        .alloc_ok(alloc_ok), .free_valid(free_valid), .free_preg(free_preg),
        .commit_alloc(commit_alloc), .flush(flush), .free_count(free_count)
    );

    int checks = 0;
    int errors = 0;

    // Model: fl = indices available to allocate in order, sp = allocated but not committed.
    int fl[$];
    int sp[$];

    typedef struct {
        logic [1:0] ar; logic [1:0] fv; int fp0; int fp1; logic [1:0] ca; logic fls;
        logic ok; int cnt; int p0; int p1;
    } vec_t;
    vec_t tbl[10];

    function automatic int pc(logic [1:0] v);
        return int'(v[0]) + int'(v[1]);
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        fl.delete();
        sp.delete();
        for (int i = 0; i < DEPTH; i++) fl.push_back(32 + i);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; alloc_req = 2'b11; free_valid = 2'b11; free_preg = '0;
        commit_alloc = 2'b11; flush = 1'b1;
        #1 chk("rst_alloc_ok", int'(alloc_ok), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; alloc_req = '0; free_valid = '0; commit_alloc = '0; flush = 1'b0;
        model_reset();
        #1 chk("rst_free_count", int'(free_count), DEPTH);
    endtask

    // One cycle: drive at negedge, compare against the model, then advance the model.
    task automatic cyc(input logic [1:0] ar, input logic [1:0] fv, input int fp0, input int fp1,
                       input logic [1:0] ca, input logic fls);
        int  k;
        int  n;
        bit  ok;
        @(negedge clk);
        alloc_req = ar; free_valid = fv; commit_alloc = ca; flush = fls;
        free_preg[0] = 6'(fp0); free_preg[1] = 6'(fp1);
        #1;
        k  = pc(ar);
        ok = !fls && (k <= fl.size());
        chk("alloc_ok", int'(alloc_ok), int'(ok));
        chk("free_count", int'(free_count), fl.size());
        if (ok) begin
            n = 0;
            for (int w = 0; w < 2; w++) begin
                if (ar[w]) begin
                    chk("alloc_preg", int'(alloc_preg[w]), fl[n]);
                    n++;
                end
            end
        end
        for (int c = 0; c < pc(ca); c++) if (sp.size() > 0) void'(sp.pop_front());
        if (fls) begin
            while (sp.size() > 0) fl.push_front(sp.pop_back());
        end else if (ok) begin
            for (int c = 0; c < k; c++) sp.push_back(fl.pop_front());
        end
        if (fv[0]) fl.push_back(fp0);
        if (fv[1]) fl.push_back(fp1);
    endtask

    initial begin
        int prev;
        logic [1:0] ar, fv, ca;
        logic fls;
        int room;

        rst = 1'b1; alloc_req = '0; free_valid = '0; free_preg = '0;
        commit_alloc = '0; flush = 1'b0;

        // ar fv fp0 fp1 ca fls | ok cnt p0 p1
        tbl[0] = '{2'b11, 2'b00, 0, 0, 2'b00, 1'b0, 1'b1, 32, 32, 33};
        tbl[1] = '{2'b11, 2'b00, 0, 0, 2'b00, 1'b0, 1'b1, 30, 34, 35};
        tbl[2] = '{2'b11, 2'b00, 0, 0, 2'b00, 1'b0, 1'b1, 28, 36, 37};
        tbl[3] = '{2'b00, 2'b00, 0, 0, 2'b11, 1'b0, 1'b1, 26, 0, 0};
        tbl[4] = '{2'b11, 2'b00, 0, 0, 2'b00, 1'b1, 1'b0, 26, 0, 0};
        tbl[5] = '{2'b01, 2'b00, 0, 0, 2'b00, 1'b0, 1'b1, 30, 34, 0};
        tbl[6] = '{2'b11, 2'b00, 0, 0, 2'b00, 1'b0, 1'b1, 29, 35, 36};
        tbl[7] = '{2'b11, 2'b00, 0, 0, 2'b11, 1'b1, 1'b0, 27, 0, 0};
        tbl[8] = '{2'b10, 2'b00, 0, 0, 2'b00, 1'b0, 1'b1, 28, 0, 36};
        tbl[9] = '{2'b00, 2'b00, 0, 0, 2'b00, 1'b0, 1'b1, 27, 0, 0};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].ar, tbl[i].fv, tbl[i].fp0, tbl[i].fp1, tbl[i].ca, tbl[i].fls);
            chk("tbl_ok", int'(alloc_ok), int'(tbl[i].ok));
            chk("tbl_cnt", int'(free_count), tbl[i].cnt);
            if (tbl[i].ok && tbl[i].ar[0]) chk("tbl_p0", int'(alloc_preg[0]), tbl[i].p0);
            if (tbl[i].ok && tbl[i].ar[1]) chk("tbl_p1", int'(alloc_preg[1]), tbl[i].p1);
        end

        // Empty list: alloc refused, same-cycle free becomes visible next cycle.
        do_reset();
        repeat (16) cyc(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
        repeat (16) cyc(2'b00, 2'b00, 0, 0, 2'b11, 1'b0);
        cyc(2'b01, 2'b01, 5, 0, 2'b00, 1'b0);
        chk("empty_ok", int'(alloc_ok), 0);
        chk("empty_cnt", int'(free_count), 0);
        cyc(2'b01, 2'b00, 0, 0, 2'b00, 1'b0);
        chk("refill_ok", int'(alloc_ok), 1);
        chk("refill_p0", int'(alloc_preg[0]), 5);
        cyc(2'b00, 2'b01, 7, 0, 2'b01, 1'b0);
        cyc(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
        chk("one_left_ok", int'(alloc_ok), 0);
        chk("one_left_cnt", int'(free_count), 1);
        cyc(2'b10, 2'b00, 0, 0, 2'b00, 1'b0);
        chk("way1_ok", int'(alloc_ok), 1);
        chk("way1_p1", int'(alloc_preg[1]), 7);

        // Steady-state wrap: pointers lap the buffer, count holds.
        do_reset();
        cyc(2'b01, 2'b00, 0, 0, 2'b00, 1'b0);
        prev = sp[sp.size()-1];
        for (int i = 0; i < 40; i++) begin
            cyc(2'b01, 2'b01, prev, 0, 2'b01, 1'b0);
            chk("wrap_cnt", int'(free_count), 31);
            prev = sp[sp.size()-1];
        end

        // Random traffic within the protocol.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            ar  = 2'($urandom);
            ca  = 2'($urandom);
            if (pc(ca) > sp.size()) ca = (sp.size() >= 1) ? 2'b01 : 2'b00;
            fls = ($urandom_range(0, 15) == 0);
            fv  = 2'($urandom);
            room = DEPTH - fl.size() - sp.size() + pc(ca);
            if (pc(fv) > room) fv = (room >= 1) ? 2'b01 : 2'b00;
            cyc(ar, fv, $urandom_range(0, 63), $urandom_range(0, 63), ca, fls);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
